fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined femtoRV32 core. It replaces the single-PC-register fetch path with a pipelined request engine and a DEPTH-entry prefetch queue. It arbitrates politely for the shared single-port memory, absorbs decode stalls, and discards stale fetches on a redirect (branch, jump or trap). It sits between the unified memory and the IF/ID pipeline register, and feeds decode a (PC, instruction) pair with valid/ready.

---
 rtl/femto_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_pkg.sv
// Shared constants for the femtoRV32 pipelined core.
// Width, NOP encoding and reset PC defaults.
package femto_pkg;

  localparam int unsigned FEMTO_XLEN = 32;
  localparam logic [31:0] FEMTO_NOP = 32'h0000_0013;
  localparam logic [31:0] FEMTO_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x W synchronous FIFO.
// Clear wins over push; head is read straight from storage.
module fetch_fifo
  import femto_pkg::*;
#(
  parameter int unsigned W = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     valid_o,
  output logic [W-1:0]             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch front end with prefetch queue.
// One request in flight; redirect flushes queue and kills the response.
module fetch_queue
  import femto_pkg::*;
#(
  parameter int unsigned     XLEN     = FEMTO_XLEN,
  parameter int unsigned     ADDR_W   = 12,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FEMTO_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_inst,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;

  logic [CNT_W-1:0]  count;
  logic              fifo_valid;
  logic [2*XLEN-1:0] head;
  logic [CNT_W:0]    occ;
  logic              space;
  logic              pop;
  logic              push;
  logic              req_raw;
  logic              gnt;
  logic [XLEN-1:0]   target_pc;

  assign pop = fifo_valid && out_ready;

  // Occupancy counts the in-flight slot so a response always fits.
  always_comb begin
    occ = {1'b0, count}
        + (CNT_W+1)'(pend_q)
        - (CNT_W+1)'(pop);
  end

  assign space    = (occ < (CNT_W+1)'(DEPTH));
  assign req_raw  = !redirect_valid && !halt && space;
  assign mem_req  = req_raw && rst;
  assign gnt      = req_raw && mem_gnt;
  assign mem_addr = fetch_pc_q[ADDR_W-1:0];

  assign push      = pend_q && !redirect_valid;
  assign target_pc = redirect_pc & ~XLEN'(3);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      pend_d     = 1'b0;
    end else begin
      if (pend_q) pend_d = 1'b0;
      if (gnt) begin
        pend_d     = 1'b1;
        pend_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
    end
  end

  fetch_fifo #(
    .W     (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({pend_pc_q, mem_rdata}),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .count_o (count),
    .valid_o (fifo_valid),
    .head_o  (head)
  );

  assign out_valid = fifo_valid;
  assign out_pc    = fifo_valid ? head[2*XLEN-1:XLEN] : '0;
  assign out_inst  = fifo_valid ? head[XLEN-1:0] : XLEN'(FEMTO_NOP);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Memory model answers one cycle after each granted request.
module tb_fetch_queue;

  localparam int XLEN = 32;
  localparam int ADDR_W = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [XLEN-1:0]   mem_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              halt;
  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_inst;
  logic              out_ready;

  int pass_cnt = 0;
  int total = 0;
  logic [31:0] popped[$];

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready)
  );

  function automatic logic [31:0] imem(input logic [ADDR_W-1:0] a);
    case (a)
      12'h000: return 32'h0050_0093;
      12'h004: return 32'h0010_0113;
      default: return 32'hA000_0000 | 32'(a);
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_rdata <= imem(mem_addr);
  end

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) popped.push_back(out_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one settle step into cycle 0 after release.
  task automatic do_reset(input logic rdy);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    mem_gnt = 1'b1;
    out_ready = rdy;
    repeat (2) tick();
    popped.delete();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    mem_gnt = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP)
      $display("FAIL rst_outputs: got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h",
               out_valid, out_pc, out_inst, NOP);
    else pass_cnt++;
    total++;
    if (mem_req !== 1'b0)
      $display("FAIL rst_req: got %b want 0", mem_req);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000)
      $display("FAIL rel_c0_req: got req=%b addr=%h want req=1 addr=000",
               mem_req, mem_addr);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0 || mem_addr !== 12'h004)
      $display("FAIL rel_c1: got v=%b addr=%h want v=0 addr=004",
               out_valid, mem_addr);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0050_0093)
      $display("FAIL rel_c2: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00500093",
               out_valid, out_pc, out_inst);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== 32'h0010_0113)
      $display("FAIL rel_c3: got v=%b pc=%h inst=%h want v=1 pc=4 inst=00100113",
               out_valid, out_pc, out_inst);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    do_reset(1'b0);
    repeat (9) tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL fill_full: got v=%b pc=%h req=%b want v=1 pc=0 req=0",
               out_valid, out_pc, mem_req);
    else pass_cnt++;
    tick();
    out_ready = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h010 || out_pc !== 32'h0)
      $display("FAIL fill_resume: got req=%b addr=%h pc=%h want req=1 addr=010 pc=0",
               mem_req, mem_addr, out_pc);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i))
        $display("FAIL fill_drain%0d: got v=%b pc=%h want v=1 pc=%h",
                 i, out_valid, out_pc, 32'(4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_gnt_stall();
    do_reset(1'b1);
    repeat (5) tick();
    mem_gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 12'h014)
        $display("FAIL gnt_hold%0d: got req=%b addr=%h want req=1 addr=014",
                 i, mem_req, mem_addr);
      else pass_cnt++;
    end
    tick();
    mem_gnt = 1'b1;
    #1;
    total++;
    if (mem_addr !== 12'h014)
      $display("FAIL gnt_retry: got addr=%h want 014", mem_addr);
    else pass_cnt++;
    repeat (12) tick();
    total++;
    if (popped.size() < 10)
      $display("FAIL gnt_count: got %0d pops want >= 10", popped.size());
    else pass_cnt++;
    for (int i = 0; i < popped.size(); i++) begin
      total++;
      if (popped[i] !== 32'(4 * i))
        $display("FAIL gnt_seq%0d: got pc=%h want %h", i, popped[i], 32'(4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    logic seen;
    do_reset(1'b1);
    repeat (5) tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h014)
      $display("FAIL rd_pre: got req=%b addr=%h want req=1 addr=014",
               mem_req, mem_addr);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    total++;
    if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h10)
      $display("FAIL rd_cycle: got req=%b v=%b pc=%h want req=0 v=1 pc=10",
               mem_req, out_valid, out_pc);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 12'h080)
      $display("FAIL rd_r1: got v=%b req=%b addr=%h want v=0 req=1 addr=080",
               out_valid, mem_req, mem_addr);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rd_r2: got v=%b want 0", out_valid);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_inst !== 32'hA000_0080)
      $display("FAIL rd_r3: got v=%b pc=%h inst=%h want v=1 pc=80 inst=a0000080",
               out_valid, out_pc, out_inst);
    else pass_cnt++;
    tick();
    seen = 1'b0;
    foreach (popped[i]) if (popped[i] == 32'h14) seen = 1'b1;
    total++;
    if (seen !== 1'b0)
      $display("FAIL rd_killed: got 0x14 seen=%b want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    total++;
    if (mem_req !== 1'b0)
      $display("FAIL b2b_first: got req=%b want 0", mem_req);
    else pass_cnt++;
    tick();
    redirect_pc = 32'h203;
    #1;
    total++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL b2b_second: got req=%b v=%b want req=0 v=0",
               mem_req, out_valid);
    else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h200)
      $display("FAIL b2b_req: got req=%b addr=%h want req=1 addr=200",
               mem_req, mem_addr);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL b2b_gap: got v=%b want 0", out_valid);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200)
      $display("FAIL b2b_out: got v=%b pc=%h want v=1 pc=200", out_valid, out_pc);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    repeat (4) tick();
    halt = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || out_pc !== 32'h8)
      $display("FAIL halt_c4: got req=%b pc=%h want req=0 pc=8", mem_req, out_pc);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC || out_inst !== 32'hA000_000C)
      $display("FAIL halt_land: got v=%b pc=%h inst=%h want v=1 pc=c inst=a000000c",
               out_valid, out_pc, out_inst);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL halt_idle: got v=%b req=%b want v=0 req=0", out_valid, mem_req);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (mem_req !== 1'b0)
      $display("FAIL halt_hold: got req=%b want 0", mem_req);
    else pass_cnt++;
    tick();
    halt = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h010)
      $display("FAIL halt_resume: got req=%b addr=%h want req=1 addr=010",
               mem_req, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    repeat (4) tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0)
      $display("FAIL mid_pre: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 32'h0 ||
        mem_req !== 1'b0)
      $display("FAIL mid_async: got v=%b pc=%h inst=%h req=%b want v=0 pc=0 inst=%h req=0",
               out_valid, out_pc, out_inst, mem_req, NOP);
    else pass_cnt++;
    repeat (2) tick();
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h000)
      $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=000",
               mem_req, mem_addr);
    else pass_cnt++;
    repeat (2) tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h0050_0093)
      $display("FAIL mid_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00500093",
               out_valid, out_pc, out_inst);
    else pass_cnt++;
  endtask

  initial begin
    mem_rdata = '0;
    test_reset();
    test_fill();
    test_gnt_stall();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
